hs_fifo_ctrl_m: RTL and testbench

- Parametrised, clocked successor to the single-stage req/ack control cell.
- Bridges two req/ack handshake channels through a DEPTH-entry data buffer.
- Supports four-phase (return-to-zero) or two-phase (transition) signalling, selected by parameter.
- Emits a one-cycle capture strobe per accepted word (clocked replacement for the local latch clock), plus occupancy and protocol-error status.

---
 rtl/hs_fifo_ctrl_m.sv | 78 +++++++
 tb/tb_hs_fifo_ctrl_m.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hs_fifo_ctrl_m.sv
// hs_fifo_ctrl_m: req/ack handshake bridge through a DEPTH-entry buffer, four- or two-phase signalling
module hs_fifo_ctrl_m #(
   parameter int WIDTH  = 32,
   parameter int DEPTH  = 2,
   parameter bit PHASE4 = 1'b1
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       in_req,
   output logic                       in_ack,
   input  logic [WIDTH-1:0]           in_data,
   output logic                       out_req,
   input  logic                       out_ack,
   output logic [WIDTH-1:0]           out_data,
   output logic                       cap_pulse,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       proto_err
);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
   localparam logic [1:0] I_IDLE    = 2'd0;
   localparam logic [1:0] I_ACK     = 2'd1;
   localparam logic [1:0] I_WAITLOW = 2'd2;
   localparam logic [1:0] O_IDLE    = 2'd0;
   localparam logic [1:0] O_REQ     = 2'd1;
   localparam logic [1:0] O_WAITLOW = 2'd2;
   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [1:0]       ist;
   logic [1:0]       ost;
   logic             ack_q;
   logic             not_full;
   logic             push;
   logic             pop;
   logic             issue;
   logic             stray;
   // handshake decisions, all from registered state and sampled inputs
   always_comb begin
      not_full = count < CW'(DEPTH);
      push     = not_full && (PHASE4 ? (ist == I_IDLE && in_req) : (in_req != in_ack));
      pop      = ost == O_REQ && (PHASE4 ? out_ack : (out_ack == out_req));
      issue    = ost == O_IDLE && count != '0 && (PHASE4 ? !out_ack : (out_ack == out_req));
      stray    = ost == O_IDLE && (PHASE4 ? out_ack : (out_ack != ack_q));
   end
   // buffer storage; occupancy gates every read so the contents need no reset
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= in_data;
   end
   // input/output handshake state, pointers, occupancy and sticky error
   always_ff @(posedge clk) begin
      if (reset) begin
         ist       <= PHASE4 ? I_WAITLOW : I_IDLE;
         ost       <= O_IDLE;
         in_ack    <= 1'b0;
         out_req   <= 1'b0;
         out_data  <= '0;
         cap_pulse <= 1'b0;
         count     <= '0;
         proto_err <= 1'b0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         ack_q     <= 1'b0;
      end else begin
         ist       <= push ? I_ACK : (ist != I_IDLE && !in_req) ? I_IDLE : ist;
         in_ack    <= PHASE4 ? (push | (in_ack & in_req)) : (push ? in_req : in_ack);
         ost       <= issue ? O_REQ : pop ? (PHASE4 ? O_WAITLOW : O_IDLE) : (ost == O_WAITLOW && !out_ack) ? O_IDLE : ost;
         out_req   <= issue ? (PHASE4 ? 1'b1 : ~out_req) : (PHASE4 && pop) ? 1'b0 : out_req;
         out_data  <= issue ? mem[rd_ptr] : out_data;
         cap_pulse <= push;
         count     <= count + CW'(push) - CW'(pop);
         proto_err <= proto_err | stray;
         wr_ptr    <= push ? (wr_ptr == PW'(DEPTH - 1) ? '0 : wr_ptr + PW'(1)) : wr_ptr;
         rd_ptr    <= pop ? (rd_ptr == PW'(DEPTH - 1) ? '0 : rd_ptr + PW'(1)) : rd_ptr;
         ack_q     <= out_ack;
      end
   end
endmodule

// File: tb/tb_hs_fifo_ctrl_m.sv
// tb_hs_fifo_ctrl_m: scoreboard bench for a four-phase and a two-phase instance of hs_fifo_ctrl_m
module tb_hs_fifo_ctrl_m;
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;
   logic        a_in_req, a_in_ack, a_out_req, a_out_ack, a_cap, a_err;
   logic [31:0] a_in_data, a_out_data;
   logic [1:0]  a_count;
   logic        b_in_req, b_in_ack, b_out_req, b_out_ack, b_cap, b_err;
   logic [7:0]  b_in_data, b_out_data;
   logic [1:0]  b_count;
   int errors = 0;
   int checks = 0;
   int a_caps = 0, b_caps = 0, a_sent = 0, b_sent = 0, b_toggles = 0;
   int a_dly = 0, b_dly = 0, a_dmax = 0, b_dmax = 0;
   bit a_auto = 1'b0, a_stray = 1'b0, rst_q = 1'b1, a_req_q = 1'b0, b_req_q = 1'b0;
   logic [31:0] qa[$];
   logic [7:0]  qb[$];

   hs_fifo_ctrl_m #(.WIDTH(32), .DEPTH(2), .PHASE4(1'b1)) u_a (
      .clk(clk), .reset(reset), .in_req(a_in_req), .in_ack(a_in_ack), .in_data(a_in_data),
      .out_req(a_out_req), .out_ack(a_out_ack), .out_data(a_out_data),
      .cap_pulse(a_cap), .count(a_count), .proto_err(a_err));

   hs_fifo_ctrl_m #(.WIDTH(8), .DEPTH(3), .PHASE4(1'b0)) u_b (
      .clk(clk), .reset(reset), .in_req(b_in_req), .in_ack(b_in_ack), .in_data(b_in_data),
      .out_req(b_out_req), .out_ack(b_out_ack), .out_data(b_out_data),
      .cap_pulse(b_cap), .count(b_count), .proto_err(b_err));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, want %0h", name, act, exp);
      end
   endtask

   task automatic a_expect(input logic [31:0] d);
      qa.push_back(d);
      a_sent++;
   endtask

   task automatic b_expect(input logic [7:0] d);
      qb.push_back(d);
      b_sent++;
   endtask

   // four-phase consumer: acks after a random delay, or holds a stray ack on demand
   initial begin
      a_out_ack = 1'b0;
      forever begin
         @(posedge clk);
         #2;
         if (reset) a_out_ack = 1'b0;
         else if (a_stray) a_out_ack = 1'b1;
         else if (a_auto && a_out_req && !a_out_ack) begin
            if (a_dly == 0) a_out_ack = 1'b1;
            else a_dly--;
         end else if (!a_out_req && a_out_ack) begin
            a_out_ack = 1'b0;
            a_dly = $urandom_range(0, a_dmax);
         end
      end
   end

   // two-phase consumer: echoes out_req after a random delay
   initial begin
      b_out_ack = 1'b0;
      forever begin
         @(posedge clk);
         #2;
         if (reset) b_out_ack = 1'b0;
         else if (b_out_req != b_out_ack) begin
            if (b_dly == 0) begin
               b_out_ack = b_out_req;
               b_dly = $urandom_range(0, b_dmax);
            end else b_dly--;
         end
      end
   end

   always @(posedge clk) rst_q <= reset;

   // monitor: every new downstream request must carry the oldest expected word
   always @(negedge clk) begin
      if (!rst_q) begin
         if (a_out_req && !a_req_q) begin
            if (qa.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL a_unexpected_req: out_data=%0h, want no request", a_out_data);
            end else check("a_out_data", a_out_data, qa.pop_front());
         end
         if (b_out_req != b_req_q) begin
            b_toggles++;
            if (qb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL b_unexpected_req: out_data=%0h, want no request", b_out_data);
            end else check("b_out_data", 32'(b_out_data), 32'(qb.pop_front()));
         end
         if (a_cap) a_caps++;
         if (b_cap) b_caps++;
      end
      a_req_q = a_out_req;
      b_req_q = b_out_req;
   end

   task automatic a_wait_ack(input logic v, input string name);
      for (int i = 0; i < 400 && a_in_ack != v; i++) @(negedge clk);
      check(name, 32'(a_in_ack), 32'(v));
   endtask

   task automatic a_send(input logic [31:0] d);
      a_in_data = d;
      a_in_req = 1'b1;
      a_expect(d);
      a_wait_ack(1'b1, "a_ack_high");
      a_in_req = 1'b0;
      a_wait_ack(1'b0, "a_ack_low");
   endtask

   task automatic b_send(input logic [7:0] d);
      b_in_data = d;
      b_in_req = ~b_in_req;
      b_expect(d);
      for (int i = 0; i < 400 && b_in_ack != b_in_req; i++) @(negedge clk);
      check("b_ack", 32'(b_in_ack), 32'(b_in_req));
   endtask

   task automatic a_drain();
      int i;
      for (i = 0; i < 400; i++) begin
         if (a_count == 2'd0 && !a_out_req && !a_out_ack && !a_in_ack && qa.size() == 0) break;
         @(negedge clk);
      end
      check("a_drained", 32'(i < 400), 32'd1);
   endtask

   task automatic b_drain();
      int i;
      for (i = 0; i < 400; i++) begin
         if (b_count == 2'd0 && b_out_req == b_out_ack && b_in_ack == b_in_req && qb.size() == 0) break;
         @(negedge clk);
      end
      check("b_drained", 32'(i < 400), 32'd1);
   endtask

   task automatic pulse_reset();
      reset = 1'b1;
      b_in_req = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      qa.delete();
      qb.delete();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation still running at %0t", $time);
      $fatal(1);
   end

   initial begin
      int ip, ia, c0;
      reset = 1'b1;
      a_in_req = 1'b0;
      a_in_data = '0;
      b_in_req = 1'b0;
      b_in_data = '0;
      repeat (2) @(negedge clk);
      check("rst_a_in_ack", 32'(a_in_ack), 32'd0);
      check("rst_a_out_req", 32'(a_out_req), 32'd0);
      check("rst_a_out_data", a_out_data, 32'd0);
      check("rst_a_cap", 32'(a_cap), 32'd0);
      check("rst_a_count", 32'(a_count), 32'd0);
      check("rst_a_err", 32'(a_err), 32'd0);
      check("rst_b_in_ack", 32'(b_in_ack), 32'd0);
      check("rst_b_out_req", 32'(b_out_req), 32'd0);
      check("rst_b_count", 32'(b_count), 32'd0);
      reset = 1'b0;
      @(negedge clk);
      // single word latency, four-phase
      a_in_data = 32'hDEADBEEF;
      a_in_req = 1'b1;
      a_expect(32'hDEADBEEF);
      @(negedge clk);
      check("lat_cap_e0", 32'(a_cap), 32'd1);
      check("lat_ack_e0", 32'(a_in_ack), 32'd1);
      check("lat_oreq_e0", 32'(a_out_req), 32'd0);
      check("lat_count_e0", 32'(a_count), 32'd1);
      @(negedge clk);
      check("lat_cap_e1", 32'(a_cap), 32'd0);
      check("lat_oreq_e1", 32'(a_out_req), 32'd1);
      check("lat_odata_e1", a_out_data, 32'hDEADBEEF);
      a_in_req = 1'b0;
      @(negedge clk);
      check("lat_ack_drop", 32'(a_in_ack), 32'd0);
      check("lat_count_held", 32'(a_count), 32'd1);
      a_auto = 1'b1;
      a_drain();
      // backpressure with the consumer stalled
      a_auto = 1'b0;
      a_send(32'h1);
      a_send(32'h2);
      check("bp_count_full", 32'(a_count), 32'd2);
      a_in_data = 32'h3;
      a_in_req = 1'b1;
      a_expect(32'h3);
      repeat (5) @(negedge clk);
      check("bp_third_unacked", 32'(a_in_ack), 32'd0);
      check("bp_count_still_full", 32'(a_count), 32'd2);
      ip = -1;
      ia = -1;
      a_auto = 1'b1;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (ip < 0 && a_count == 2'd1) ip = i;
         if (a_in_ack) begin
            ia = i;
            break;
         end
      end
      check("bp_ack_after_pop", 32'(ia - ip), 32'd1);
      a_in_req = 1'b0;
      a_wait_ack(1'b0, "bp_ack_low");
      a_drain();
      // two-phase, four words under immediate echo
      b_dmax = 0;
      c0 = b_toggles;
      for (int k = 0; k < 4; k++) b_send(8'hA0 + 8'(k));
      b_drain();
      check("b4_toggles", 32'(b_toggles - c0), 32'd4);
      check("b4_ack_eq_req", 32'(b_in_ack), 32'(b_in_req));
      check("b4_count", 32'(b_count), 32'd0);
      // simultaneous push and pop at count 1
      b_in_data = 8'h11;
      b_in_req = ~b_in_req;
      b_expect(8'h11);
      @(negedge clk);
      check("sim_count_push", 32'(b_count), 32'd1);
      @(negedge clk);
      check("sim_issue_data", 32'(b_out_data), 32'h11);
      b_in_data = 8'h22;
      b_in_req = ~b_in_req;
      b_expect(8'h22);
      @(negedge clk);
      check("sim_count_same", 32'(b_count), 32'd1);
      check("sim_cap", 32'(b_cap), 32'd1);
      b_drain();
      // randomized traffic, wrapping the three-entry buffer several times
      b_dmax = 3;
      for (int k = 0; k < 10; k++) begin
         b_send(8'($urandom));
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      b_drain();
      check("b_no_err", 32'(b_err), 32'd0);
      a_dmax = 2;
      for (int k = 0; k < 10; k++) begin
         a_send($urandom);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      a_drain();
      check("a_no_err", 32'(a_err), 32'd0);
      // reset in the middle of a transfer with the request held high
      a_dmax = 0;
      a_auto = 1'b0;
      a_in_data = 32'h77;
      a_in_req = 1'b1;
      a_expect(32'h77);
      a_wait_ack(1'b1, "mid_ack");
      @(negedge clk);
      check("mid_count", 32'(a_count), 32'd1);
      check("mid_oreq", 32'(a_out_req), 32'd1);
      pulse_reset();
      check("mid_rst_in_ack", 32'(a_in_ack), 32'd0);
      check("mid_rst_out_req", 32'(a_out_req), 32'd0);
      check("mid_rst_out_data", a_out_data, 32'd0);
      check("mid_rst_cap", 32'(a_cap), 32'd0);
      check("mid_rst_count", 32'(a_count), 32'd0);
      c0 = a_caps;
      repeat (5) @(negedge clk);
      check("held_req_no_cap", 32'(a_caps - c0), 32'd0);
      check("held_req_no_ack", 32'(a_in_ack), 32'd0);
      check("held_req_count", 32'(a_count), 32'd0);
      a_in_req = 1'b0;
      @(negedge clk);
      a_send(32'h55);
      @(negedge clk);
      check("rearm_one_cap", 32'(a_caps - c0), 32'd1);
      a_auto = 1'b1;
      a_drain();
      // stray acknowledge while idle
      a_auto = 1'b0;
      a_stray = 1'b1;
      repeat (3) @(negedge clk);
      check("stray_err", 32'(a_err), 32'd1);
      check("stray_count", 32'(a_count), 32'd0);
      a_send(32'h99);
      @(negedge clk);
      check("stray_no_pop_count", 32'(a_count), 32'd1);
      check("stray_no_issue", 32'(a_out_req), 32'd0);
      a_stray = 1'b0;
      a_auto = 1'b1;
      a_drain();
      check("stray_err_sticky", 32'(a_err), 32'd1);
      check("a_caps_total", 32'(a_caps), 32'(a_sent));
      check("b_caps_total", 32'(b_caps), 32'(b_sent));
      pulse_reset();
      check("stray_err_cleared", 32'(a_err), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
